// File: rtl/if_stage_if.sv
// Fetch-stage interface bundle: the decode handoff, the branch redirect bus
// and the instruction-memory request/response channel.
interface if_stage_if;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  // The fetch stage drives the request and the decode handoff.
  modport master (
    input  ds_allowin,
    input  br_bus,
    input  inst_sram_addr_ok,
    input  inst_sram_data_ok,
    input  inst_sram_rdata,
    output fs_to_ds_valid,
    output fs_to_ds_bus,
    output inst_sram_req,
    output inst_sram_addr
  );

  // The environment (decode, execute, memory) sees the opposite directions.
  modport slave (
    output ds_allowin,
    output br_bus,
    output inst_sram_addr_ok,
    output inst_sram_data_ok,
    output inst_sram_rdata,
    input  fs_to_ds_valid,
    input  fs_to_ds_bus,
    input  inst_sram_req,
    input  inst_sram_addr
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage. Keeps at most one memory request in flight,
// buffers the returned word until decode accepts it, and handles execute
// redirects by retargeting the pc and dropping any response already owed
// to the superseded address.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic       clk,
  input  logic       reset,
  if_stage_if.master fs
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst_buf;
  logic        r_cancel;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_inst_buf_nxt;
  logic        w_cancel_nxt;

  logic        w_br_taken;
  logic [31:0] w_br_target;

  assign w_br_taken  = fs.br_bus[32];
  assign w_br_target = fs.br_bus[31:0];

  // The memory always sees the current pc; a request is only raised in REQ.
  assign fs.inst_sram_req  = (r_state == S_REQ);
  assign fs.inst_sram_addr = r_pc;

  // A buffered instruction is offered to decode unless a redirect kills it.
  assign fs.fs_to_ds_valid = (r_state == S_HOLD) && !w_br_taken;
  assign fs.fs_to_ds_bus   = {r_inst_buf, r_pc};

  // State and fetch registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_inst_buf <= 32'h0;
      r_cancel   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_inst_buf <= w_inst_buf_nxt;
      r_cancel   <= w_cancel_nxt;
    end
  end

  // Next-state logic: sequencing of request/response plus redirect handling.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_inst_buf_nxt = r_inst_buf;
    w_cancel_nxt   = r_cancel;

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
      end

      S_REQ: begin
        // The old address is accepted even when a redirect arrives in the
        // same cycle, so its response must be remembered as stale.
        if (fs.inst_sram_addr_ok) begin
          w_state_nxt  = S_WAIT;
          w_cancel_nxt = w_br_taken;
        end
      end

      S_WAIT: begin
        if (fs.inst_sram_data_ok) begin
          if (r_cancel || w_br_taken) begin
            w_state_nxt  = S_REQ;
            w_cancel_nxt = 1'b0;
          end else begin
            w_state_nxt    = S_HOLD;
            w_inst_buf_nxt = fs.inst_sram_rdata;
          end
        end else if (w_br_taken) begin
          // Repeated redirects still owe exactly one dropped response.
          w_cancel_nxt = 1'b1;
        end
      end

      S_HOLD: begin
        if (w_br_taken) begin
          w_state_nxt = S_REQ;
        end else if (fs.ds_allowin) begin
          w_state_nxt = S_REQ;
          w_pc_nxt    = r_pc + 32'd4;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A redirect always wins over sequential pc advance.
    if (w_br_taken) begin
      w_pc_nxt = w_br_target;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for the fetch stage. Kept responses are pushed to a
// scoreboard when the bench returns data_ok; the decode-side output is
// compared against the queue head whenever the stage offers an instruction.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  logic clk = 1'b0;
  logic reset;

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] sb_q[$];

  if_stage_if u_if();

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .fs    (u_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
    check({tag, "_req"}, 64'(u_if.inst_sram_req), 64'(req));
    check({tag, "_addr"}, 64'(u_if.inst_sram_addr), 64'(addr));
  endtask

  task automatic chk_valid(input string tag, input logic v);
    check({tag, "_valid"}, 64'(u_if.fs_to_ds_valid), 64'(v));
  endtask

  // Drive one cycle of inputs, settle to the falling edge, run the scoreboard.
  task automatic step(input logic al, input logic bt, input logic [31:0] tgt,
                      input logic ao, input logic dok, input logic [31:0] rd,
                      input logic keep, input logic [31:0] kaddr);
    u_if.ds_allowin        = al;
    u_if.br_bus            = {bt, tgt};
    u_if.inst_sram_addr_ok = ao;
    u_if.inst_sram_data_ok = dok;
    u_if.inst_sram_rdata   = rd;
    if (dok && keep) sb_q.push_back({rd, kaddr});
    #4;
    if (sb_q.size() == 0) begin
      check("sb_no_entry_valid", 64'(u_if.fs_to_ds_valid), 64'd0);
    end else if (u_if.fs_to_ds_valid) begin
      check("sb_bus", u_if.fs_to_ds_bus, sb_q[0]);
      if (al) void'(sb_q.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_step();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Normal fetch from REQ: addr_ok now, data_ok next cycle, handoff after.
  task automatic fetch_ok(input string tag, input logic [31:0] addr, input logic [31:0] rd);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_req({tag, "_issue"}, 1'b1, addr);
    tick();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, rd, 1'b1, addr);
    chk_valid({tag, "_wait"}, 1'b0);
    tick();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_valid({tag, "_hold"}, 1'b1);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    u_if.ds_allowin        = 1'b0;
    u_if.br_bus            = 33'h0;
    u_if.inst_sram_addr_ok = 1'b0;
    u_if.inst_sram_data_ok = 1'b0;
    u_if.inst_sram_rdata   = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    // Outputs while reset is held
    chk_req("rst", 1'b0, RESET_PC);
    chk_valid("rst", 1'b0);
    reset = 1'b0;

    // IDLE cycle after release
    quiet_step();
    chk_req("idle", 1'b0, RESET_PC);
    chk_valid("idle", 1'b0);
    tick();

    // First fetch and sequential follow-on address
    fetch_ok("f0", 32'h1c00_0000, 32'h0280_0421);
    quiet_step();
    chk_req("f1_first", 1'b1, 32'h1c00_0004);
    tick();

    // Stalled addr_ok, two-cycle data latency, then decode back-pressure
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_req("f1_issue", 1'b1, 32'h1c00_0004);
    tick();
    quiet_step();
    chk_valid("f1_wait0", 1'b0);
    tick();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'haaaa_0001, 1'b1, 32'h1c00_0004);
    chk_valid("f1_wait1", 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      quiet_step();
      chk_valid("f1_stall", 1'b1);
      chk_req("f1_stall", 1'b0, 32'h1c00_0004);
      tick();
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_valid("f1_take", 1'b1);
    tick();

    // Redirect in the addr_ok cycle of 0x1c000008: response is dropped
    step(1'b0, 1'b1, 32'h1c00_0100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_req("br_req", 1'b1, 32'h1c00_0008);
    tick();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hdead_beef, 1'b0, 32'h0);
    chk_valid("br_drop", 1'b0);
    chk_req("br_drop", 1'b0, 32'h1c00_0100);
    tick();
    fetch_ok("br_tgt", 32'h1c00_0100, 32'h1111_1111);

    // Two redirects while a response is owed: one drop, latest target wins
    step(1'b0, 1'b1, 32'h1c00_0300, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_req("rbr_req", 1'b1, 32'h1c00_0104);
    tick();
    step(1'b0, 1'b1, 32'h1c00_0400, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_req("rbr_wait", 1'b0, 32'h1c00_0300);
    tick();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hbad0_bad0, 1'b0, 32'h0);
    chk_valid("rbr_drop", 1'b0);
    tick();
    fetch_ok("rbr_tgt", 32'h1c00_0400, 32'h2222_2222);

    // Redirect coincident with data_ok in WAIT
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_req("wbr_req", 1'b1, 32'h1c00_0404);
    tick();
    step(1'b0, 1'b1, 32'h1c00_0200, 1'b0, 1'b1, 32'h3333_3333, 1'b0, 32'h0);
    chk_valid("wbr_data", 1'b0);
    tick();

    // Redirect in HOLD with decode ready: no handoff, no pc+4
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_req("wbr_next", 1'b1, 32'h1c00_0200);
    tick();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4444_4444, 1'b0, 32'h0);
    tick();
    step(1'b1, 1'b1, 32'h1c00_0500, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_valid("hbr", 1'b0);
    tick();

    // Redirect in REQ without addr_ok retargets the pending request
    step(1'b0, 1'b1, 32'hffff_fffc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_req("hbr_next", 1'b1, 32'h1c00_0500);
    tick();

    // pc wraparound after handoff at the top of the address space
    fetch_ok("wrap", 32'hffff_fffc, 32'h1234_5678);

    // Stray data_ok in REQ is ignored
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5555_5555, 1'b0, 32'h0);
    chk_req("wrap_next", 1'b1, 32'h0000_0000);
    chk_valid("stray", 1'b0);
    tick();
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_req("stray_after", 1'b1, 32'h0000_0000);
    tick();

    // Asynchronous reset in WAIT abandons the fetch
    u_if.inst_sram_addr_ok = 1'b0;
    reset = 1'b1;
    #1;
    chk_req("mid_rst", 1'b0, RESET_PC);
    chk_valid("mid_rst", 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Redirect in IDLE
    step(1'b0, 1'b1, 32'h1c00_0600, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_req("idle_br", 1'b0, RESET_PC);
    tick();
    fetch_ok("idle_tgt", 32'h1c00_0600, 32'h6666_6666);
    quiet_step();
    chk_req("idle_tgt_next", 1'b1, 32'h1c00_0604);
    tick();

    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h1c00_0000; first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  one clock; reset is asynchronous and active-high.
REQ-004 ds_allowin  input  1  decode stage can accept an instruction this cycle.
REQ-005 br_bus  input  33  {br_taken[32], br_target[31:0]}; br_taken is a one-cycle redirect pulse from execute.
REQ-006 fs_to_ds_valid  output  1  fs_to_ds_bus holds a valid fetched instruction.
REQ-007 fs_to_ds_bus  output  64  {inst[63:32], pc[31:0]}; pc in [31:0], matching the decode-stage unpack.
REQ-008 inst_sram_req  output  1  fetch request to instruction memory.
REQ-009 inst_sram_addr  output  32  fetch address; word aligned.
REQ-010 inst_sram_addr_ok  input  1  request accepted this cycle when inst_sram_req=1.
REQ-011 inst_sram_data_ok  input  1  read data for the oldest accepted request is valid.
REQ-012 inst_sram_rdata  input  32  instruction word, valid with data_ok.

Function
REQ-013 States: IDLE, REQ, WAIT, HOLD; at most one outstanding memory request.
REQ-014 Registers: pc[31:0], inst_buf[31:0], cancel (1 bit).
REQ-015 inst_sram_req=1 only in REQ; inst_sram_addr=pc in every state.
REQ-016 IDLE -> REQ unconditionally on the first clock after reset deasserts.
REQ-017 REQ with addr_ok=1 -> WAIT; REQ with addr_ok=0 -> stay in REQ.
REQ-018 WAIT with data_ok=1 and cancel=0 -> HOLD, inst_buf <= inst_sram_rdata.
REQ-019 WAIT with data_ok=1 and cancel=1 -> REQ, data dropped, cancel <= 0.
REQ-020 HOLD: fs_to_ds_valid = ~br_taken; fs_to_ds_bus = {inst_buf, pc}.
REQ-021 fs_to_ds_valid=0 in IDLE, REQ and WAIT.
REQ-022 Handoff: HOLD with ds_allowin=1 and br_taken=0 -> pc <= pc+4 (modulo 2^32, wraps at 32'hFFFF_FFFC to 0), state -> REQ.
REQ-023 HOLD with ds_allowin=0 and br_taken=0: hold; inst_buf, pc and outputs stable.
REQ-024 br_taken=1 always sets pc <= br_target; it takes priority over the pc+4 update.
REQ-025 br_taken in REQ with addr_ok=0: stay REQ; the next cycle's address is br_target.
REQ-026 br_taken in REQ with addr_ok=1: old address accepted; state -> WAIT, cancel <= 1.
REQ-027 br_taken in WAIT, data_ok=0: cancel <= 1, stay WAIT.
REQ-028 br_taken in WAIT, data_ok=1: drop data regardless of cancel; state -> REQ, cancel <= 0.
REQ-029 br_taken in HOLD: discard inst_buf, no handoff, state -> REQ.
REQ-030 br_taken in IDLE: pc <= br_target; state -> REQ.
REQ-031 Repeated br_taken while cancel=1: pc updates to the latest br_target; exactly one response is still dropped.
REQ-032 Latency without redirect: addr_ok at cycle t, data_ok at t+k (k>=1) -> fs_to_ds_valid at t+k+1.
REQ-033 Back-to-back peak: one instruction per 3 cycles when addr_ok and data_ok each return after 1 cycle.
REQ-034 data_ok outside WAIT is a protocol violation; ignored, no state change.

Reset
REQ-035 Async assertion forces state=IDLE, pc=RESET_PC, cancel=0, inst_buf=0.
REQ-036 During reset and in IDLE: inst_sram_req=0, fs_to_ds_valid=0, inst_sram_addr=RESET_PC.
REQ-037 Reset mid-transaction (WAIT/HOLD) abandons it; the memory model is reset together with the stage.

Verification
REQ-038 Reset release; addr_ok=1 and data_ok=1 one cycle later, rdata=32'h02800421 -> req at 32'h1c000000; valid with bus {32'h02800421, 32'h1c000000}; then req at 32'h1c000004.
REQ-039 ds_allowin=0 for 5 cycles in HOLD -> valid held high, bus stable; pc advances only on the allowin cycle.
REQ-040 br_taken, target 32'h1c000100, in the addr_ok cycle of fetch 32'h1c000008 -> that response is dropped; next req at 32'h1c000100; no valid for 32'h1c000008.
REQ-041 br_taken coincident with data_ok in WAIT, target 32'h1c000200 -> no HOLD; next cycle req at 32'h1c000200.
REQ-042 br_taken in HOLD with ds_allowin=1 -> fs_to_ds_valid=0 that cycle; pc=br_target; no pc+4.
REQ-043 pc=32'hFFFF_FFFC handoff -> next req address 32'h0000_0000.
